// File: rtl/rom_stream_reader_pkg.sv
// rtl/rom_stream_reader_pkg.sv - shared geometry and FSM encodings for the ROM burst reader
package rom_stream_reader_pkg;

    // Geometry of the 16x16 ROM core this reader feeds.
    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 16;

    // Default output buffer depth; two entries sustain one word per cycle
    // across the one-cycle ROM read latency.
    localparam int DEFAULT_BUF_DEPTH = 2;

    // Burst FSM encodings.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/rom_stream_reader_stream_fifo.sv
// rtl/rom_stream_reader_stream_fifo.sv - small synchronous FIFO buffering ROM words ahead of the stream output
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   push_i/push_data_i write one entry (ignored when full and not popping)
//   pop_i              remove the head entry (ignored when empty)
//   head_data_o        head entry; holds the most recently popped entry while empty
//   count_o            number of stored entries
//   empty_o, full_o    occupancy flags
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still take a word in the same cycle its head leaves.
    assign do_push = push_i && (!full_o || do_pop);

    // While empty, present the last word that left so the output does not
    // glitch to a stale slot.
    assign head_data_o = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - burst reader issuing consecutive ROM reads and streaming the words out
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start/start_addr/count   burst request (count 0 = full ROM), accepted only when idle
//   rom_en/rom_addr          read request to the ROM wrapper
//   rom_data                 ROM word, valid the cycle after rom_en
//   out_valid/out_ready      downstream handshake
//   out_data/out_last        head word and end-of-burst marker
//   busy                     burst in progress, through the done cycle
//   done                     one-cycle pulse after the final word transfers
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int REM_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic              in_flight_q, in_flight_d;
    logic              last_flight_q, last_flight_d;
    logic              done_q, done_d;

    logic [DATA_W:0]   fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              issue;
    logic              final_pop;
    logic [OCC_W-1:0]  occupancy;

    assign pop = out_valid && out_ready;

    // Words already committed to the buffer after this cycle, counting the
    // read in flight and crediting a word leaving now.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, in_flight_q}
                     - {{CNT_W{1'b0}}, pop};

    assign issue     = (state_q == ST_ISSUE) && (occupancy < DEPTH_V);
    assign final_pop = (state_q == ST_DRAIN) && pop && out_last;

    assign rom_en    = issue;
    assign rom_addr  = addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = !fifo_empty && fifo_head[DATA_W];
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        in_flight_d   = issue;
        last_flight_d = issue && (remaining_q == REM_W'(1));
        done_d        = final_pop;

        case (state_q)
            ST_IDLE: begin
                // A start in the done cycle is ignored because busy is still high.
                if (start && !done_q) begin
                    addr_d      = start_addr;
                    remaining_d = (count == '0) ? REM_W'(1 << ADDR_W) : {1'b0, count};
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (final_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            in_flight_q   <= 1'b0;
            last_flight_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            in_flight_q   <= in_flight_d;
            last_flight_q <= last_flight_d;
            done_q        <= done_d;
        end
    end

    // The issue rule guarantees space, so the push never finds the FIFO full.
    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (in_flight_q),
        .push_data_i ({last_flight_q, rom_data}),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - directed self-checking bench for rom_stream_reader
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  start_addr;
    logic [3:0]  count;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] got_data [$];
    logic        got_last [$];
    logic [3:0]  rom_addrs [$];
    int rom_pulses = 0;
    int done_cnt = 0;
    int issued = 0;
    int popped = 0;
    int max_occ = 0;

    always #5 clk = ~clk;

    rom_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural ROM: mem[i] = A000 + i, one-cycle registered read.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 16'hA000 + {12'h0, rom_addr};
    end

    // Records transfers and reads that will occur at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                popped++;
            end
            if (rom_en) begin
                rom_pulses++;
                rom_addrs.push_back(rom_addr);
                issued++;
            end
            if (done) done_cnt++;
            if (issued - popped > max_occ) max_occ = issued - popped;
        end
    end

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        rom_addrs.delete();
        rom_pulses = 0;
        done_cnt = 0;
        issued = 0;
        popped = 0;
        max_occ = 0;
    endtask

    task automatic do_start(input logic [3:0] a, input logic [3:0] c);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({rom_en, rom_addr, out_valid, out_data, out_last, busy, done} !== 25'h0)
            $display("FAIL reset_held: got %h expected 0", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done});
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({rom_en, out_valid, busy, done} !== 4'h0)
            $display("FAIL reset_released: got %b expected 0000", {rom_en, out_valid, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic        ev [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        logic [15:0] ed [8] = '{16'h0, 16'h0, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'h0, 16'h0};
        logic        el [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        logic        edn[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic        eb [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        out_ready = 1'b1;
        clear_log();
        do_start(4'd3, 4'd4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total_cnt++;
                if ({rom_en, rom_addr} !== {1'b1, 4'd3})
                    $display("FAIL basic_first_issue: got en=%b addr=%0d expected en=1 addr=3", rom_en, rom_addr);
                else pass_cnt++;
            end
            total_cnt++;
            if ({out_valid, out_last, done, busy} !== {ev[i], el[i], edn[i], eb[i]} ||
                (ev[i] && out_data !== ed[i]))
                $display("FAIL basic_cycle%0d: got v=%b d=%h l=%b done=%b busy=%b expected v=%b d=%h l=%b done=%b busy=%b",
                         i, out_valid, out_data, out_last, done, busy, ev[i], ed[i], el[i], edn[i], eb[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_data !== 16'hA006)
            $display("FAIL basic_hold_data: got %h expected A006", out_data);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] ea [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        out_ready = 1'b1;
        clear_log();
        do_start(4'd14, 4'd4);
        wait_done(40, ok);
        total_cnt++;
        if (!ok || got_data.size() != 4 || rom_addrs.size() != 4)
            $display("FAIL wrap_count: got done=%b words=%0d reads=%0d expected done=1 words=4 reads=4", ok, got_data.size(), rom_addrs.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (got_data[i] !== 16'hA000 + {12'h0, ea[i]} || rom_addrs[i] !== ea[i] || got_last[i] !== (i == 3))
                    $display("FAIL wrap_word%0d: got d=%h a=%0d l=%b expected d=%h a=%0d", i, got_data[i], rom_addrs[i], got_last[i], 16'hA000 + {12'h0, ea[i]}, ea[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_full_sweep();
        bit ok;
        logic [3:0] a;
        out_ready = 1'b1;
        clear_log();
        do_start(4'd5, 4'd0);
        wait_done(80, ok);
        total_cnt++;
        if (!ok || rom_pulses != 16 || got_data.size() != 16)
            $display("FAIL sweep_count: got done=%b pulses=%0d words=%0d expected done=1 pulses=16 words=16", ok, rom_pulses, got_data.size());
        else begin
            pass_cnt++;
            total_cnt++;
            a = 4'd5;
            ok = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (got_data[i] !== 16'hA000 + {12'h0, a} || got_last[i] !== (i == 15)) ok = 1'b0;
                a = a + 4'd1;
            end
            if (!ok) $display("FAIL sweep_words: got first=%h last=%h expected A005..A004 in order", got_data[0], got_data[15]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        bit seen_done = 1'b0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [15:0] pd = 16'h0;
        logic        pl = 1'b0;
        clear_log();
        out_ready = 1'b1;
        do_start(4'd2, 4'd6);
        for (int i = 0; i < 80 && !seen_done; i++) begin
            @(posedge clk); #1;
            out_ready = pat[i % 6];
            @(negedge clk);
            if (pv && !pr) begin
                total_cnt++;
                if ({out_valid, out_data, out_last} !== {1'b1, pd, pl})
                    $display("FAIL bp_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
                else pass_cnt++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (done) seen_done = 1'b1;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (!seen_done || got_data.size() != 6)
            $display("FAIL bp_count: got done=%b words=%0d expected done=1 words=6", seen_done, got_data.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                total_cnt++;
                if (got_data[i] !== 16'hA002 + 16'(i) || got_last[i] !== (i == 5))
                    $display("FAIL bp_word%0d: got d=%h l=%b expected d=%h", i, got_data[i], got_last[i], 16'hA002 + 16'(i));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (max_occ > 2)
            $display("FAIL bp_occupancy: got %0d expected <= 2", max_occ);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        out_ready = 1'b1;
        clear_log();
        do_start(4'd1, 4'd5);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 4'd9; count = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, ok);
        repeat (6) @(negedge clk);
        total_cnt++;
        if (!ok || got_data.size() != 5 || done_cnt != 1)
            $display("FAIL busy_start_count: got done=%b words=%0d dones=%0d expected done=1 words=5 dones=1", ok, got_data.size(), done_cnt);
        else begin
            pass_cnt++;
            for (int i = 0; i < 5; i++) begin
                total_cnt++;
                if (got_data[i] !== 16'hA001 + 16'(i))
                    $display("FAIL busy_start_word%0d: got %h expected %h", i, got_data[i], 16'hA001 + 16'(i));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        out_ready = 1'b1;
        clear_log();
        do_start(4'd4, 4'd8);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({rom_en, rom_addr, out_valid, out_data, out_last, busy, done} !== 25'h0)
            $display("FAIL midreset_outputs: got %h expected 0", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (5) @(negedge clk);
        total_cnt++;
        if (done_cnt != 0 || got_data.size() != 0 || busy !== 1'b0)
            $display("FAIL midreset_quiet: got dones=%0d words=%0d busy=%b expected 0 0 0", done_cnt, got_data.size(), busy);
        else pass_cnt++;
        do_start(4'd0, 4'd2);
        wait_done(30, ok);
        total_cnt++;
        if (!ok || got_data.size() != 2 || done_cnt != 1)
            $display("FAIL midreset_restart_count: got done=%b words=%0d dones=%0d expected 1 2 1", ok, got_data.size(), done_cnt);
        else begin
            pass_cnt++;
            total_cnt++;
            if (got_data[0] !== 16'hA000 || got_data[1] !== 16'hA001 || got_last[1] !== 1'b1)
                $display("FAIL midreset_restart_words: got %h %h last=%b expected A000 A001 last=1", got_data[0], got_data[1], got_last[1]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_addr = 4'd0;
        count = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_full_sweep();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
